// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
//   WIDTH_DEFAULT : default operand width
//   multState_t   : controller state encoding (IDLE / RUN / DONE)
package mult_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } multState_t;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand magnitudes, accumulator, sign fix-up
// and the held product register.
//   clk, reset        : clock, asynchronous active-high reset
//   load              : latch operands and clear accumulator (start accepted)
//   step              : one shift-add iteration
//   finish            : DONE cycle; present the signed result and remember it
//   signed_op, opA/B  : operation type and operands
//   MulAns            : product (live in DONE, held at last product otherwise)
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    output logic [2*WIDTH-1:0]   MulAns
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] lastProd;
    logic               negRes;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] result;

    // Magnitude is kept unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic isSigned);
        return (isSigned && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] applySign(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    // Upper half plus multiplicand; the extra bit is the carry shifted back in.
    always_comb begin
        partial = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (mplier[0]) begin
            partial = partial + {1'b0, mcand};
        end
    end

    assign result = applySign(acc, negRes);
    assign MulAns = finish ? result : lastProd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            negRes   <= 1'b0;
            lastProd <= '0;
        end else if (load) begin
            mcand    <= magnitude(opA, signed_op);
            mplier   <= magnitude(opB, signed_op);
            negRes   <= signed_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            acc      <= '0;
        end else if (step) begin
            acc      <= {partial, acc[WIDTH-1:1]};
            mplier   <= mplier >> 1;
        end else if (finish) begin
            lastProd <= result;
        end
    end

endmodule

// File: rtl/mult_ctrl.sv
// Multiplier controller: three-state FSM, iteration counter and pipeline
// interlock, wrapping the shift-add datapath.
//   clk, reset   : clock, asynchronous active-high reset
//   start        : multiply request (honoured only in IDLE)
//   signed_op    : 1 = MULT, 0 = MULTU
//   opA, opB     : operands, sampled with start
//   rd_hilo      : MFHI/MFLO decoded in the pipeline
//   busy         : operation in progress (RUN or DONE)
//   stall        : interlock, rd_hilo while busy
//   hilo_we      : one-cycle Hi/Lo write strobe (DONE)
//   MulAns       : product for the Hi/Lo register
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int CYCLES = WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    input  logic                 rd_hilo,
    output logic                 busy,
    output logic                 stall,
    output logic                 hilo_we,
    output logic [2*WIDTH-1:0]   MulAns
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    multState_t       state;
    multState_t       nextState;
    logic [CNT_W-1:0] count;
    logic             load;
    logic             step;
    logic             finish;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= nextState;
            if (load) begin
                count <= '0;
            end else if (step) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // RUN length depends only on the counter, never on operand values.
    always_comb begin
        nextState = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        busy      = 1'b0;
        hilo_we   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (count == LAST_CNT) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                finish    = 1'b1;
                hilo_we   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Hi/Lo is only updated at the end of DONE, so a read there must also wait.
    assign stall = rd_hilo & busy;

    mult_datapath #(.WIDTH(WIDTH)) uDatapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .signed_op (signed_op),
        .opA       (opA),
        .opB       (opB),
        .MulAns    (MulAns)
    );

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; MulAns is 2*WIDTH bits.
REQ-002 The block SHALL have parameter CYCLES, default WIDTH, giving the number of shift-add iterations.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: multiply request, sampled only in IDLE.
REQ-006 The block SHALL have port signed_op, input, 1 bit: 1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-007 The block SHALL have port opA, input, WIDTH bits: multiplicand, sampled with start.
REQ-008 The block SHALL have port opB, input, WIDTH bits: multiplier, sampled with start.
REQ-009 The block SHALL have port rd_hilo, input, 1 bit: decode of an MFHI or MFLO in the pipeline.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-011 The block SHALL have port stall, output, 1 bit: pipeline interlock request.
REQ-012 The block SHALL have port hilo_we, output, 1 bit: one-cycle write strobe to the Hi/Lo register.
REQ-013 The block SHALL have port MulAns, output, 2*WIDTH bits: product presented to the Hi/Lo register.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the block SHALL latch |opA|, |opB| and the result sign (signed_op & (opA[msb]^opB[msb])), clear the accumulator and counter, and enter RUN.
REQ-016 For signed_op=0, the block SHALL use the raw operands as magnitudes.
REQ-017 Each RUN cycle SHALL add the multiplicand to the upper accumulator half if the multiplier LSB is 1, shift the accumulator right one bit (carry included), and increment the counter.
REQ-018 When the counter reaches CYCLES-1, the block SHALL go RUN -> DONE; RUN therefore lasts exactly CYCLES cycles regardless of operand values (zero operands included).
REQ-019 In DONE, the block SHALL drive MulAns with the accumulator, two's-complement negated if the sign is set, assert hilo_we for exactly that cycle, then return to IDLE.
REQ-020 Latency SHALL be fixed: with start accepted at edge t, hilo_we is high in the cycle after edge t+CYCLES (CYCLES+1 cycles after start, 33 cycles at default).
REQ-021 In RUN and DONE, the block SHALL ignore start; the request is not queued.
REQ-022 The block SHALL drive stall = rd_hilo & busy; a read in DONE also stalls, because Hi/Lo updates only at the end of DONE.
REQ-023 A start arriving in the same cycle as hilo_we SHALL be ignored; it is accepted in the following IDLE cycle.
REQ-024 The block SHALL hold MulAns at the last written product outside DONE, so that Hi/Lo may reload it harmlessly.
REQ-025 The block SHALL handle -2^(WIDTH-1) correctly: its magnitude is an unsigned WIDTH-bit value, and no overflow is permitted.

Reset
REQ-026 reset SHALL force, asynchronously: state=IDLE, counter=0, accumulator=0, MulAns=0, hilo_we=0, busy=0, stall=0.
REQ-027 A reset during RUN or DONE SHALL abort the operation with no hilo_we pulse.
REQ-028 After reset deassertion, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-030 The shift-add accumulator, magnitude and negation logic SHALL sit in sub-module mult_datapath; the FSM, counter and stall logic SHALL sit in mult_ctrl.

Verification
REQ-031 The bench SHALL cover: MULTU opA=3, opB=5 -> hilo_we exactly 33 cycles after start, MulAns=64'h0000_0000_0000_000F.
REQ-032 The bench SHALL cover: MULT opA=32'hFFFF_FFFE (-2), opB=3 -> MulAns=64'hFFFF_FFFF_FFFF_FFFA.
REQ-033 The bench SHALL cover: MULTU opA=opB=32'hFFFF_FFFF -> 64'hFFFF_FFFE_0000_0001; MULT opA=opB=32'h8000_0000 -> 64'h4000_0000_0000_0000.
REQ-034 The bench SHALL cover: second start at cycle 10 of RUN -> ignored, exactly one hilo_we pulse, busy low immediately after DONE.
REQ-035 The bench SHALL cover: rd_hilo=1 continuously from start -> stall high for 33 cycles (RUN+DONE) and low the cycle after hilo_we.
REQ-036 The bench SHALL cover: reset asserted mid-RUN (cycle 10) -> all outputs 0 immediately, no hilo_we, next start completes normally.
